// File: rtl/regfile_wb.sv
// Write-side driver for the integer register file: merges ALU and queued LSU results
// onto a registered write port and tracks pending long-latency destinations. Option: WB_BYPASS_EN.
module regfile_wb #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [4:0]        alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [4:0]        lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              sb_set_ena,
  input  logic [4:0]        sb_set_addr,
  output logic [31:0]       busy,
  output logic              w_ena,
  output logic [4:0]        w_addr,
  output logic [DATA_W-1:0] w_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [4:0]        addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       busy_q, busy_d;
  logic              w_ena_q, w_ena_d;
  logic [4:0]        w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;

  logic              push, pop, enq, byp, fifo_empty;
  logic              clr_ena;
  logic [4:0]        clr_addr;
  logic [31:0]       set_vec, clr_vec;

  assign lsu_ready  = (count_q != CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = lsu_valid & lsu_ready;
  assign pop        = ~alu_valid & ~fifo_empty;

`ifdef WB_BYPASS_EN
  // Idle output and empty queue: an offered LSU result goes straight to the port.
  assign byp = ~alu_valid & fifo_empty & push;
`else
  assign byp = 1'b0;
`endif

  assign enq = push & ~byp;

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ALU has strict priority; x0 targets consume the source but never write.
  always_comb begin
    w_ena_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    clr_ena  = 1'b0;
    clr_addr = lsu_addr;
    if (alu_valid) begin
      w_ena_d  = (alu_addr != 5'd0);
      w_addr_d = alu_addr;
      w_data_d = alu_data;
    end else if (pop) begin
      w_ena_d  = (addr_mem[rd_ptr_q] != 5'd0);
      w_addr_d = addr_mem[rd_ptr_q];
      w_data_d = data_mem[rd_ptr_q];
      clr_ena  = 1'b1;
      clr_addr = addr_mem[rd_ptr_q];
    end else if (byp) begin
      w_ena_d  = (lsu_addr != 5'd0);
      w_addr_d = lsu_addr;
      w_data_d = lsu_data;
      clr_ena  = 1'b1;
      clr_addr = lsu_addr;
    end
  end

  // Set beats clear on the same register; x0 never goes pending.
  always_comb begin
    set_vec = sb_set_ena ? (32'd1 << sb_set_addr) : 32'd0;
    clr_vec = clr_ena    ? (32'd1 << clr_addr)    : 32'd0;
    busy_d  = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= lsu_addr;
      data_mem[wr_ptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      w_ena_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      w_ena_q  <= w_ena_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign busy   = busy_q;
  assign w_ena  = w_ena_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: ALU path, LSU path with scoreboard, FIFO full,
// x0 suppression, set/clear collision and mid-operation reset.
module tb_regfile_wb;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, lsu_valid, sb_set_ena;
  logic [4:0]        alu_addr, lsu_addr, sb_set_addr;
  logic [DATA_W-1:0] alu_data, lsu_data;
  logic              lsu_ready, w_ena;
  logic [31:0]       busy;
  logic [4:0]        w_addr;
  logic [DATA_W-1:0] w_data;

  int n_chk = 0;
  int n_err = 0;

  regfile_wb #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .sb_set_ena(sb_set_ena), .sb_set_addr(sb_set_addr), .busy(busy),
    .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; sb_set_ena = 0;
  endtask

  // Offer one LSU result with the ALU idle and check it reaches the port.
  task automatic lsu_write(input string tag, input logic [4:0] a, input logic [63:0] d, input logic exp_ena);
    lsu_valid = 1; lsu_addr = a; lsu_data = d;
    step();
    lsu_valid = 0;
`ifndef WB_BYPASS_EN
    chk({tag, "_q"}, w_ena, 0);
    step();
`endif
    chk({tag, "_ena"}, w_ena, exp_ena);
    if (exp_ena) begin
      chk({tag, "_addr"}, w_addr, a);
      chk({tag, "_data"}, w_data, d);
    end
  endtask

  initial begin
    rst = 1; idle();
    alu_addr = 0; alu_data = 0; lsu_addr = 0; lsu_data = 0; sb_set_addr = 0;
    step(); step();
    chk("rst_wena", w_ena, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    step();
    chk("rst_ready", lsu_ready, 1);

    // ALU only
    alu_valid = 1; alu_addr = 5; alu_data = 64'h1234;
    step();
    alu_valid = 0;
    chk("alu_ena", w_ena, 1);
    chk("alu_addr", w_addr, 5);
    chk("alu_data", w_data, 64'h1234);
    step();
    chk("alu_idle", w_ena, 0);

    // LSU with scoreboard
    sb_set_ena = 1; sb_set_addr = 7;
    step();
    sb_set_ena = 0;
    chk("sb_set7", busy, 32'h80);
    lsu_valid = 1; lsu_addr = 7; lsu_data = 64'hAA;
    step();
    lsu_valid = 0;
`ifndef WB_BYPASS_EN
    chk("lsu_q_ena", w_ena, 0);
    chk("lsu_q_busy", busy, 32'h80);
    step();
`endif
    chk("lsu_ena", w_ena, 1);
    chk("lsu_addr", w_addr, 7);
    chk("lsu_data", w_data, 64'hAA);
    chk("lsu_busy", busy, 0);
    step();
    chk("lsu_idle", w_ena, 0);

    // FIFO fill under continuous ALU traffic
    alu_valid = 1; alu_addr = 1; alu_data = 64'h11; lsu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("full_rdy_pre", lsu_ready, 1);
      lsu_addr = 5'(10 + i); lsu_data = 64'(100 + i);
      step();
      chk("full_alu_addr", w_addr, 1);
    end
    chk("full_rdy", lsu_ready, 0);
    step();
    chk("full_hold", lsu_ready, 0);
    lsu_valid = 0; alu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_ena", w_ena, 1);
      chk("drain_addr", w_addr, 5'(10 + i));
      chk("drain_data", w_data, 64'(100 + i));
      chk("drain_rdy", lsu_ready, 1);
    end
    step();
    chk("drain_idle", w_ena, 0);

    // x0 suppression
    alu_valid = 1; alu_addr = 0; alu_data = 64'hFFFF;
    sb_set_ena = 1; sb_set_addr = 0;
    step();
    idle();
    chk("x0_alu", w_ena, 0);
    chk("x0_busy", busy, 0);
    lsu_write("x0_lsu", 5'd0, 64'h55, 1'b0);
    step();
    chk("x0_after", w_ena, 0);
    lsu_write("x0_cnt", 5'd4, 64'h44, 1'b1);
    step();

    // ALU write does not clear busy; set/clear collision
    sb_set_ena = 1; sb_set_addr = 9;
    step();
    sb_set_ena = 0;
    alu_valid = 1; alu_addr = 9; alu_data = 64'h99;
    step();
    chk("alu_nclr_ena", w_ena, 1);
    chk("alu_nclr_busy", busy, 32'h200);
    alu_addr = 2; lsu_valid = 1; lsu_addr = 3; lsu_data = 64'h33;
    sb_set_ena = 1; sb_set_addr = 3;
    step();
    lsu_valid = 0; alu_valid = 0;
    chk("col_pre_busy", busy, 32'h208);
    step();
    sb_set_ena = 0;
    chk("col_ena", w_ena, 1);
    chk("col_addr", w_addr, 3);
    chk("col_busy", busy, 32'h208);

    // Reset mid-operation
    rst = 1; step(); rst = 0;
    chk("rst2_busy", busy, 0);
    sb_set_ena = 1; sb_set_addr = 10;
    step();
    sb_set_addr = 11; alu_valid = 1; alu_addr = 1; lsu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      lsu_addr = 5'(10 + i); lsu_data = 64'(200 + i);
      step();
      sb_set_ena = 0;
    end
    chk("mid_busy", busy, 32'h0C00);
    rst = 1; lsu_valid = 0; alu_addr = 5;
    step();
    rst = 0; alu_valid = 0;
    chk("mid_rst_ena", w_ena, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", lsu_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_stale", w_ena, 0);
    end
    lsu_write("mid_fresh", 5'd20, 64'hBEEF, 1'b1);
    step();
    chk("mid_end", w_ena, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
